// File: rtl/mem_stage_lsu.sv
// Memory stage LSU: lane-aligns stores, extracts/extends loads, one op in flight.
// Optional misalignment trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage_lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_instr,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              in_wen,
  input  logic [REG_W-1:0]  in_dst,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic              out_wen,
  output logic [REG_W-1:0]  out_dst,
  output logic [XLEN-1:0]   out_result,
  output logic              out_misaligned,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [XLEN/8-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t state, state_nx;

  logic            accept;
  logic            is_mem;
  logic            mis;
  logic            ld_q;
  logic            uns_q;
  logic            mis_q;
  logic [OW-1:0]   off_in;
  logic [OW-1:0]   off_q;
  logic [NB-1:0]   strobe_in;
  logic [XLEN-1:0] sdata_in;
  logic [XLEN-1:0] raw;

  assign is_mem = in_is_load | in_is_store;
  assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept = in_valid & in_ready;

  assign out_valid  = (state == HOLD);
  assign dreq_valid = (state == REQ);
  assign out_misaligned = mis_q;

  assign off_in = in_alu_out[OW-1:0];
  assign strobe_in = in_is_store
    ? NB'(((16'd1 << (16'd1 << in_size)) - 16'd1) << off_in)
    : '0;
  assign sdata_in = in_store_data << {off_in, 3'b000};
  assign raw = dresp_data >> {off_q, 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
  logic [3:0] amask;
  assign amask = (4'd1 << in_size) - 4'd1;
  assign mis = is_mem & (|(in_alu_out[3:0] & amask));
`else
  assign mis = 1'b0;
`endif

  function automatic logic [XLEN-1:0] ext(
    input logic [XLEN-1:0] d,
    input logic [1:0]      sz,
    input logic            u
  );
    logic [XLEN-1:0] r;
    r = d;
    case (sz)
      2'd0: r = u ? XLEN'(d[7:0])  : XLEN'($signed(d[7:0]));
      2'd1: r = u ? XLEN'(d[15:0]) : XLEN'($signed(d[15:0]));
      2'd2: r = u ? XLEN'(d[31:0]) : XLEN'($signed(d[31:0]));
      default: r = d;
    endcase
    return r;
  endfunction

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state: accept into REQ or HOLD, drain HOLD on out_ready
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = (is_mem & ~mis) ? REQ : HOLD;
      end
      REQ: begin
        if (dresp_data_ok) state_nx = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) state_nx = (is_mem & ~mis) ? REQ : HOLD;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // capture the instruction on accept; replace result with load data on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pc      <= '0;
      out_instr   <= '0;
      out_wen     <= 1'b0;
      out_dst     <= '0;
      out_result  <= '0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      ld_q        <= 1'b0;
      uns_q       <= 1'b0;
      mis_q       <= 1'b0;
      off_q       <= '0;
    end else if (accept) begin
      out_pc      <= in_pc;
      out_instr   <= in_instr;
      out_wen     <= in_wen & ~mis;
      out_dst     <= in_dst;
      out_result  <= in_alu_out;
      dreq_addr   <= ADDR_W'(in_alu_out);
      dreq_size   <= in_size;
      dreq_strobe <= strobe_in;
      dreq_data   <= sdata_in;
      ld_q        <= in_is_load;
      uns_q       <= in_unsigned;
      mis_q       <= mis;
      off_q       <= off_in;
    end else if ((state == REQ) && dresp_data_ok && ld_q) begin
      out_result  <= ext(raw, dreq_size, uns_q);
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: vector table, corner sequences and random ops
// checked against a byte-level model of lane alignment and extension.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_is_load;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        in_wen;
  logic [4:0]  in_dst;
  logic [63:0] in_alu_out;
  logic [63:0] in_store_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_wen;
  logic [4:0]  out_dst;
  logic [63:0] out_result;
  logic        out_misaligned;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic        wen;
    logic [4:0]  dst;
    logic [63:0] addr;
    logic [63:0] sd;
    logic [63:0] resp;
    int          w;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [63:0] res;
  } vec_t;

  vec_t tbl[8];

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_wen(in_wen), .in_dst(in_dst),
    .in_alu_out(in_alu_out), .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_wen(out_wen), .out_dst(out_dst),
    .out_result(out_result), .out_misaligned(out_misaligned),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // bytes [off, off+n) of the 8-byte lane are written
  function automatic logic [7:0] m_strb(input logic [63:0] a,
                                        input logic [1:0] sz,
                                        input logic st);
    int off = int'(a[2:0]);
    int n = 1 << sz;
    logic [7:0] s = '0;
    if (!st) return s;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  // lane byte i carries store byte i-off
  function automatic logic [63:0] m_data(input logic [63:0] a,
                                         input logic [63:0] sd);
    int off = int'(a[2:0]);
    logic [63:0] d = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) d[i*8 +: 8] = sd[(i-off)*8 +: 8];
    return d;
  endfunction

  // gather n bytes starting at lane byte off, then extend
  function automatic logic [63:0] m_load(input logic [63:0] a,
                                         input logic [1:0] sz,
                                         input logic uns,
                                         input logic [63:0] r);
    int off = int'(a[2:0]);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++)
      if (off + k < 8) v[k*8 +: 8] = r[(off+k)*8 +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic run_op(input string nm, input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_is_load = v.ld;
    in_is_store = v.st;
    in_size = v.sz;
    in_unsigned = v.uns;
    in_wen = v.wen;
    in_dst = v.dst;
    in_alu_out = v.addr;
    in_store_data = v.sd;
    in_pc = v.addr ^ 64'h100;
    in_instr = v.addr[31:0] ^ 32'hA5A5_0000;
    out_ready = 1'b1;
    dresp_data_ok = 1'b0;
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (v.ld || v.st) begin
      for (int c = 0; c <= v.w; c++) begin
        chk({nm, " dreq_valid"}, 64'(dreq_valid), 64'd1);
        chk({nm, " out_valid_req"}, 64'(out_valid), 64'd0);
        chk({nm, " dreq_addr"}, dreq_addr, v.addr);
        chk({nm, " dreq_size"}, 64'(dreq_size), 64'(v.sz));
        chk({nm, " dreq_strobe"}, 64'(dreq_strobe),
            64'(m_strb(v.addr, v.sz, v.st)));
        if (v.st) chk({nm, " dreq_data"}, dreq_data, v.data);
        if (c == v.w) begin
          dresp_data_ok = 1'b1;
          dresp_data = v.resp;
        end
        @(posedge clk); #1;
      end
      dresp_data_ok = 1'b0;
      dresp_data = {$urandom, $urandom};
    end
    chk({nm, " out_valid"}, 64'(out_valid), 64'd1);
    chk({nm, " dreq_valid_off"}, 64'(dreq_valid), 64'd0);
    chk({nm, " out_result"}, out_result, v.res);
    chk({nm, " out_wen"}, 64'(out_wen), 64'(v.wen));
    chk({nm, " out_dst"}, 64'(out_dst), 64'(v.dst));
    chk({nm, " out_pc"}, out_pc, v.addr ^ 64'h100);
    @(posedge clk); #1;
    chk({nm, " drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vec_t r;
    int k;
    logic [63:0] nbm;
    tbl[0] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 64'h8003,
               64'hAB, 64'h0, 3, 8'h08, 64'hAB00_0000, 64'h8003};
    tbl[1] = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd3, 64'h1006,
               64'h0, 64'h8001_0000_0000_0000, 1, 8'h00, 64'h0,
               64'hFFFF_FFFF_FFFF_8001};
    tbl[2] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd4, 64'h1006,
               64'h0, 64'h8001_0000_0000_0000, 0, 8'h00, 64'h0,
               64'h8001};
    tbl[3] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9, 64'h1004,
               64'h0, 64'h8000_0000_0000_0000, 2, 8'h00, 64'h0,
               64'hFFFF_FFFF_8000_0000};
    tbl[4] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 5'd0, 64'h10,
               64'h1122_3344_5566_7788, 64'h0, 0, 8'hFF,
               64'h1122_3344_5566_7788, 64'h10};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd1, 64'h7,
               64'h0, 64'hFE00_0000_0000_0000, 1, 8'h00, 64'h0,
               64'hFE};
    tbl[6] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 64'h2,
               64'hBEEF, 64'h0, 0, 8'h0C, 64'hBEEF_0000, 64'h2};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd5, 64'h1234,
               64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h1234};

    reset = 1'b1;
    in_valid = 1'b0;
    in_pc = '0;
    in_instr = '0;
    in_is_load = 1'b0;
    in_is_store = 1'b0;
    in_size = '0;
    in_unsigned = 1'b0;
    in_wen = 1'b0;
    in_dst = '0;
    in_alu_out = '0;
    in_store_data = '0;
    out_ready = 1'b1;
    dresp_data_ok = 1'b0;
    dresp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst dreq_strobe", 64'(dreq_strobe), 64'd0);
    chk("rst out_result", out_result, 64'd0);
    chk("rst out_misaligned", 64'(out_misaligned), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // back-to-back non-memory ops
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_is_load = 1'b0;
    in_is_store = 1'b0;
    in_alu_out = 64'h1234;
    in_wen = 1'b1;
    in_dst = 5'd5;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b valid0", 64'(out_valid), 64'd1);
    chk("b2b res0", out_result, 64'h1234);
    chk("b2b dst0", 64'(out_dst), 64'd5);
    chk("b2b in_ready", 64'(in_ready), 64'd1);
    in_alu_out = 64'h5678;
    in_dst = 5'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b valid1", 64'(out_valid), 64'd1);
    chk("b2b res1", out_result, 64'h5678);
    chk("b2b dst1", 64'(out_dst), 64'd6);
    @(posedge clk); #1;
    chk("b2b idle", 64'(out_valid), 64'd0);

    // writeback stall, then release with a simultaneous load accept
    in_valid = 1'b1;
    in_alu_out = 64'h9999;
    in_dst = 5'd7;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall out_valid", 64'(out_valid), 64'd1);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      chk("stall result", out_result, 64'h9999);
      chk("stall dst", 64'(out_dst), 64'd7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_is_load = 1'b1;
    in_size = 2'd1;
    in_unsigned = 1'b0;
    in_alu_out = 64'h1006;
    in_dst = 5'd8;
    #1;
    chk("release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release dreq_valid", 64'(dreq_valid), 64'd1);
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release dreq_addr", dreq_addr, 64'h1006);
    dresp_data_ok = 1'b1;
    dresp_data = 64'h8001_0000_0000_0000;
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    chk("release result", out_result, 64'hFFFF_FFFF_FFFF_8001);
    chk("release out_valid1", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a bus request
    in_valid = 1'b1;
    in_is_load = 1'b1;
    in_size = 2'd3;
    in_alu_out = 64'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midreq dreq_valid", 64'(dreq_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async dreq_valid", 64'(dreq_valid), 64'd0);
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd1);
    chk("async dreq_addr", dreq_addr, 64'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    dresp_data_ok = 1'b1;
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    chk("late ok out_valid", 64'(out_valid), 64'd0);
    chk("late ok dreq_valid", 64'(dreq_valid), 64'd0);
    chk("late ok in_ready", 64'(in_ready), 64'd1);

`ifdef MEM_MISALIGN_CHECK_EN
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_is_load = 1'b1;
    in_is_store = 1'b0;
    in_size = 2'd2;
    in_wen = 1'b1;
    in_alu_out = 64'h2002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mis dreq_valid", 64'(dreq_valid), 64'd0);
    chk("mis out_valid", 64'(out_valid), 64'd1);
    chk("mis flag", 64'(out_misaligned), 64'd1);
    chk("mis wen", 64'(out_wen), 64'd0);
    chk("mis result", out_result, 64'h2002);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 2));
      r.ld = (k == 1);
      r.st = (k == 2);
      r.sz = 2'($urandom_range(0, 3));
      r.uns = 1'($urandom_range(0, 1));
      r.wen = 1'($urandom_range(0, 1));
      r.dst = 5'($urandom);
      r.addr = {$urandom, $urandom};
`ifdef MEM_MISALIGN_CHECK_EN
      nbm = (64'd1 << r.sz) - 64'd1;
      r.addr = r.addr & ~nbm;
`else
      nbm = 64'd0;
`endif
      r.sd = {$urandom, $urandom};
      r.resp = {$urandom, $urandom};
      r.w = int'($urandom_range(0, 3));
      r.strb = m_strb(r.addr, r.sz, r.st);
      r.data = m_data(r.addr, r.sd);
      r.res = r.ld ? m_load(r.addr, r.sz, r.uns, r.resp) : r.addr;
      run_op($sformatf("rnd%0d", i), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
